hazard_unit_sb: RTL and testbench

Parametrised next-generation hazard unit for the 5-stage RISC-V core (F/DE/EX/MEM/WB). It keeps the existing services: MEM/WB forwarding, load-use stall, jump flush and branch-predictor misprediction flush. It adds a per-register busy scoreboard for a non-pipelined multi-cycle unit (MUL/DIV), WAW/RAW/structural stalls against that unit, a latency watchdog, and stall/mispredict performance counters.

---
 rtl/hazard_unit_sb_pkg.sv | 10 +
 rtl/hazard_unit_sb_if.sv | 59 +++++
 rtl/hazard_unit_sb_mc_scoreboard.sv | 84 ++++++++
 rtl/hazard_unit_sb.sv | 124 ++++++++++++
 tb/tb_hazard_unit_sb.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_unit_sb_pkg.sv
// Shared encodings for the hazard unit: forwarding mux selects and the
// PC-select value that marks a jump in EX.
package hazard_unit_sb_pkg;

   localparam logic [1:0] FWD_NONE    = 2'b00;
   localparam logic [1:0] FWD_MEM     = 2'b01;
   localparam logic [1:0] FWD_WB      = 2'b11;
   localparam logic [1:0] PC_SEL_JUMP = 2'd2;

endpackage

// File: rtl/hazard_unit_sb_if.sv
// Pipeline-to-hazard-unit bundle. The core side (master) drives the stage
// register indices and control qualifiers. The hazard unit (slave) returns
// the forwarding, stall and flush controls and the performance counters.
interface hazard_unit_sb_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
);

   logic [REG_W-1:0] rs1_DE;
   logic [REG_W-1:0] rs2_DE;
   logic [REG_W-1:0] rd_DE;
   logic [REG_W-1:0] rs1_EX;
   logic [REG_W-1:0] rs2_EX;
   logic [REG_W-1:0] rd_EX;
   logic [REG_W-1:0] rd_MEM;
   logic [REG_W-1:0] rd_WB;
   logic             rf_write_en_MEM;
   logic             rf_write_en_WB;
   logic             mem_read_en_EX;
   logic [1:0]       program_counter_controller_EX;
   logic             branch_control;
   logic             branch_decision;
   logic             mc_op_DE;
   logic             mc_issue_EX;
   logic             mc_done;
   logic [REG_W-1:0] mc_rd_done;

   logic [1:0]       forward_mode_rs1;
   logic [1:0]       forward_mode_rs2;
   logic             branch_correction;
   logic             stall_F;
   logic             stall_DE;
   logic             flush_DE;
   logic             flush_EX;
   logic             mc_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] mispredict_cnt;

   modport master (
      output rs1_DE, rs2_DE, rd_DE, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB,
             rf_write_en_MEM, rf_write_en_WB, mem_read_en_EX,
             program_counter_controller_EX, branch_control, branch_decision,
             mc_op_DE, mc_issue_EX, mc_done, mc_rd_done,
      input  forward_mode_rs1, forward_mode_rs2, branch_correction,
             stall_F, stall_DE, flush_DE, flush_EX, mc_timeout,
             stall_cnt, mispredict_cnt
   );

   modport slave (
      input  rs1_DE, rs2_DE, rd_DE, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB,
             rf_write_en_MEM, rf_write_en_WB, mem_read_en_EX,
             program_counter_controller_EX, branch_control, branch_decision,
             mc_op_DE, mc_issue_EX, mc_done, mc_rd_done,
      output forward_mode_rs1, forward_mode_rs2, branch_correction,
             stall_F, stall_DE, flush_DE, flush_EX, mc_timeout,
             stall_cnt, mispredict_cnt
   );

endinterface

// File: rtl/hazard_unit_sb_mc_scoreboard.sv
// Busy scoreboard for the non-pipelined multi-cycle unit. Tracks which
// architectural registers have a pending multi-cycle result, whether an op
// is in flight, and raises a sticky timeout when an op overstays MAX_LAT.
module mc_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int REG_W    = 5,
   parameter int MAX_LAT  = 34
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue,
   input  logic [REG_W-1:0] issue_rd,
   input  logic             done,
   input  logic [REG_W-1:0] done_rd,
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   input  logic [REG_W-1:0] rd,
   output logic             busy_rs1,
   output logic             busy_rs2,
   output logic             busy_rd,
   output logic             inflight,
   output logic             timeout
);

   localparam int                  LAT_W    = $clog2(MAX_LAT + 1);
   localparam logic [LAT_W-1:0]    LAT_MAX  = LAT_W'(MAX_LAT);
   localparam logic [LAT_W-1:0]    LAT_ONE  = LAT_W'(1);
   localparam logic [REG_W-1:0]    REG_ZERO = {REG_W{1'b0}};
   localparam logic [NUM_REGS-1:0] BIT0     = {{(NUM_REGS-1){1'b0}}, 1'b1};

   logic [NUM_REGS-1:0] busy_r;
   logic [NUM_REGS-1:0] busy_nxt_s;
   logic [NUM_REGS-1:0] clr_mask_s;
   logic [NUM_REGS-1:0] set_mask_s;
   logic                inflight_r;
   logic [LAT_W-1:0]    lat_cnt_r;
   logic                timeout_r;

   // Next busy vector: completion clears first, issue sets afterwards, x0 never busy.
   always_comb begin
      clr_mask_s = done ? (BIT0 << done_rd) : {NUM_REGS{1'b0}};
      set_mask_s = (issue && (issue_rd != REG_ZERO)) ? (BIT0 << issue_rd) : {NUM_REGS{1'b0}};
      busy_nxt_s = ((busy_r & ~clr_mask_s) | set_mask_s) & ~BIT0;
   end

   // Scoreboard, in-flight flag and latency watchdog state.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r     <= {NUM_REGS{1'b0}};
         inflight_r <= 1'b0;
         lat_cnt_r  <= {LAT_W{1'b0}};
         timeout_r  <= 1'b0;
      end else begin
         busy_r <= busy_nxt_s;
         if (issue) begin
            inflight_r <= 1'b1;
         end else if (done) begin
            inflight_r <= 1'b0;
         end else begin
            inflight_r <= inflight_r;
         end
         // Counter saturates at MAX_LAT so a stuck op cannot wrap it back to legal.
         if (issue) begin
            lat_cnt_r <= {LAT_W{1'b0}};
         end else if (inflight_r && (lat_cnt_r != LAT_MAX)) begin
            lat_cnt_r <= lat_cnt_r + LAT_ONE;
         end else begin
            lat_cnt_r <= lat_cnt_r;
         end
         if (inflight_r && !done && (lat_cnt_r == LAT_MAX)) begin
            timeout_r <= 1'b1;
         end else begin
            timeout_r <= timeout_r;
         end
      end
   end

   assign busy_rs1 = busy_r[rs1];
   assign busy_rs2 = busy_r[rs2];
   assign busy_rd  = busy_r[rd];
   assign inflight = inflight_r;
   assign timeout  = timeout_r;

endmodule

// File: rtl/hazard_unit_sb.sv
// Hazard unit for the 5-stage core: MEM/WB forwarding, load-use and
// multi-cycle (RAW/WAW/structural) stalls, jump and mispredict flushes,
// and saturating stall/mispredict counters.
module hazard_unit_sb
   import hazard_unit_sb_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int REG_W    = 5,
   parameter int MAX_LAT  = 34,
   parameter int CNT_W    = 32
) (
   input logic             clk,
   input logic             rst,
   hazard_unit_sb_if.slave hz
);

   localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             sb_busy_rs1_s;
   logic             sb_busy_rs2_s;
   logic             sb_busy_rd_s;
   logic             sb_inflight_s;
   logic             sb_timeout_s;
   logic             load_use_s;
   logic             stall_req_s;
   logic             mispredict_s;
   logic             jump_s;
   logic             flush_de_s;
   logic             stall_de_s;
   logic [1:0]       fwd_rs1_s;
   logic [1:0]       fwd_rs2_s;
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] mispredict_cnt_r;

   // MEM result is younger than WB, so it wins when both match.
   function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs,
                                          input logic [REG_W-1:0] rd_mem,
                                          input logic             we_mem,
                                          input logic [REG_W-1:0] rd_wb,
                                          input logic             we_wb);
      logic [1:0] sel;
      if ((rs != REG_ZERO) && we_mem && (rs == rd_mem)) begin
         sel = FWD_MEM;
      end else if ((rs != REG_ZERO) && we_wb && (rs == rd_wb)) begin
         sel = FWD_WB;
      end else begin
         sel = FWD_NONE;
      end
      return sel;
   endfunction

   mc_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .REG_W    (REG_W),
      .MAX_LAT  (MAX_LAT)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .issue    (hz.mc_issue_EX),
      .issue_rd (hz.rd_EX),
      .done     (hz.mc_done),
      .done_rd  (hz.mc_rd_done),
      .rs1      (hz.rs1_DE),
      .rs2      (hz.rs2_DE),
      .rd       (hz.rd_DE),
      .busy_rs1 (sb_busy_rs1_s),
      .busy_rs2 (sb_busy_rs2_s),
      .busy_rd  (sb_busy_rd_s),
      .inflight (sb_inflight_s),
      .timeout  (sb_timeout_s)
   );

   // Forwarding selects for both EX source operands.
   always_comb begin
      fwd_rs1_s = fwd_sel(hz.rs1_EX, hz.rd_MEM, hz.rf_write_en_MEM, hz.rd_WB, hz.rf_write_en_WB);
      fwd_rs2_s = fwd_sel(hz.rs2_EX, hz.rd_MEM, hz.rf_write_en_MEM, hz.rd_WB, hz.rf_write_en_WB);
   end

   // Stall/flush arbitration: any redirect squashes DE, so freezing F/DE would be wrong.
   always_comb begin
      load_use_s   = hz.mem_read_en_EX && (hz.rd_EX != REG_ZERO) &&
                     ((hz.rs1_DE == hz.rd_EX) || (hz.rs2_DE == hz.rd_EX));
      stall_req_s  = load_use_s || sb_busy_rs1_s || sb_busy_rs2_s ||
                     (sb_busy_rd_s && (hz.rd_DE != REG_ZERO)) ||
                     (hz.mc_op_DE && (sb_inflight_s || hz.mc_issue_EX));
      mispredict_s = hz.branch_control ^ hz.branch_decision;
      jump_s       = (hz.program_counter_controller_EX == PC_SEL_JUMP);
      flush_de_s   = mispredict_s || jump_s;
      stall_de_s   = stall_req_s && !flush_de_s;
   end

   // Saturating performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_r      <= {CNT_W{1'b0}};
         mispredict_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (stall_de_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (mispredict_s && (mispredict_cnt_r != CNT_MAX)) begin
            mispredict_cnt_r <= mispredict_cnt_r + CNT_ONE;
         end else begin
            mispredict_cnt_r <= mispredict_cnt_r;
         end
      end
   end

   assign hz.forward_mode_rs1  = fwd_rs1_s;
   assign hz.forward_mode_rs2  = fwd_rs2_s;
   assign hz.branch_correction = mispredict_s;
   assign hz.flush_DE          = flush_de_s;
   assign hz.flush_EX          = flush_de_s || stall_req_s;
   assign hz.stall_F           = stall_de_s;
   assign hz.stall_DE          = stall_de_s;
   assign hz.mc_timeout        = sb_timeout_s;
   assign hz.stall_cnt         = stall_cnt_r;
   assign hz.mispredict_cnt    = mispredict_cnt_r;

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Self-checking bench for hazard_unit_sb: directed scenarios followed by
// randomized traffic, all compared against a behavioural model that tracks
// pending registers, the outstanding op's issue cycle and the counters.
module tb_hazard_unit_sb;

   localparam int     NUM_REGS = 32;
   localparam int     REG_W    = 5;
   localparam int     MAX_LAT  = 34;
   localparam int     CNT_W    = 8;
   localparam longint CNT_MAX  = (longint'(1) << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst;

   hazard_unit_sb_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz ();

   hazard_unit_sb #(
      .NUM_REGS (NUM_REGS),
      .REG_W    (REG_W),
      .MAX_LAT  (MAX_LAT),
      .CNT_W    (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz)
   );

   always #5 clk = ~clk;

   int     n_cmp = 0;
   int     n_bad = 0;
   bit     busy_m [NUM_REGS];
   bit     inflight_m;
   bit     timeout_m;
   int     cyc;
   int     issue_cyc;
   longint stall_cnt_m;
   longint mis_cnt_m;
   longint saved;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_REGS; i++) busy_m[i] = 1'b0;
      inflight_m  = 1'b0;
      timeout_m   = 1'b0;
      issue_cyc   = 0;
      stall_cnt_m = 0;
      mis_cnt_m   = 0;
   endtask

   task automatic set_idle();
      hz.rs1_DE = '0; hz.rs2_DE = '0; hz.rd_DE = '0;
      hz.rs1_EX = '0; hz.rs2_EX = '0; hz.rd_EX = '0;
      hz.rd_MEM = '0; hz.rd_WB = '0;
      hz.rf_write_en_MEM = 1'b0; hz.rf_write_en_WB = 1'b0;
      hz.mem_read_en_EX = 1'b0; hz.program_counter_controller_EX = 2'd0;
      hz.branch_control = 1'b0; hz.branch_decision = 1'b0;
      hz.mc_op_DE = 1'b0; hz.mc_issue_EX = 1'b0;
      hz.mc_done = 1'b0; hz.mc_rd_done = '0;
   endtask

   function automatic logic [1:0] exp_fwd(input logic [REG_W-1:0] rs);
      if (rs != 0 && hz.rf_write_en_MEM && rs == hz.rd_MEM) return 2'b01;
      if (rs != 0 && hz.rf_write_en_WB && rs == hz.rd_WB) return 2'b11;
      return 2'b00;
   endfunction

   // One cycle: compare everything against the model, then advance the model at the edge.
   task automatic step();
      bit stall, mis, jump, fde, sde;
      #1;
      stall = (hz.mem_read_en_EX && hz.rd_EX != 0 &&
               (hz.rs1_DE == hz.rd_EX || hz.rs2_DE == hz.rd_EX))
           || busy_m[hz.rs1_DE] || busy_m[hz.rs2_DE]
           || (hz.rd_DE != 0 && busy_m[hz.rd_DE])
           || (hz.mc_op_DE && (inflight_m || hz.mc_issue_EX));
      mis  = (hz.branch_control != hz.branch_decision);
      jump = (hz.program_counter_controller_EX == 2'd2);
      fde  = mis || jump;
      sde  = stall && !fde;
      check_eq("fwd_rs1",        64'(hz.forward_mode_rs1),  64'(exp_fwd(hz.rs1_EX)));
      check_eq("fwd_rs2",        64'(hz.forward_mode_rs2),  64'(exp_fwd(hz.rs2_EX)));
      check_eq("branch_corr",    64'(hz.branch_correction), 64'(mis));
      check_eq("flush_DE",       64'(hz.flush_DE),          64'(fde));
      check_eq("flush_EX",       64'(hz.flush_EX),          64'(fde || stall));
      check_eq("stall_F",        64'(hz.stall_F),           64'(sde));
      check_eq("stall_DE",       64'(hz.stall_DE),          64'(sde));
      check_eq("mc_timeout",     64'(hz.mc_timeout),        64'(timeout_m));
      check_eq("stall_cnt",      64'(hz.stall_cnt),         64'(stall_cnt_m));
      check_eq("mispredict_cnt", 64'(hz.mispredict_cnt),    64'(mis_cnt_m));
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (inflight_m && !hz.mc_done && (cyc - issue_cyc - 1) >= MAX_LAT) timeout_m = 1'b1;
         if (hz.mc_done) busy_m[hz.mc_rd_done] = 1'b0;
         if (hz.mc_issue_EX && hz.rd_EX != 0) busy_m[hz.rd_EX] = 1'b1;
         if (hz.mc_issue_EX) begin
            inflight_m = 1'b1;
            issue_cyc  = cyc;
         end else if (hz.mc_done) begin
            inflight_m = 1'b0;
         end
         if (sde && stall_cnt_m < CNT_MAX) stall_cnt_m++;
         if (mis && mis_cnt_m < CNT_MAX) mis_cnt_m++;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      set_idle();
      step();
      rst = 1'b0;
   endtask

   task automatic issue(input int rd);
      set_idle();
      hz.mc_issue_EX = 1'b1;
      hz.rd_EX       = REG_W'(rd);
      step();
      set_idle();
   endtask

   initial begin
      cyc = 0;
      rst = 1'b1;
      set_idle();
      model_reset();
      repeat (2) @(negedge clk);
      step();
      rst = 1'b0;
      #1;
      check_eq("rst_stall_cnt", 64'(hz.stall_cnt),      64'(0));
      check_eq("rst_mis_cnt",   64'(hz.mispredict_cnt), 64'(0));
      check_eq("rst_timeout",   64'(hz.mc_timeout),     64'(0));
      step();

      // Forwarding priority and the x0 exclusion.
      hz.rs1_EX = 5; hz.rd_MEM = 5; hz.rf_write_en_MEM = 1'b1;
      hz.rd_WB = 5; hz.rf_write_en_WB = 1'b1;
      #1 check_eq("fwd_mem_prio", 64'(hz.forward_mode_rs1), 64'(2'b01));
      step();
      hz.rs1_EX = 0;
      #1 check_eq("fwd_x0", 64'(hz.forward_mode_rs1), 64'(2'b00));
      step();
      hz.rs2_EX = 5; hz.rf_write_en_MEM = 1'b0;
      #1 check_eq("fwd_wb", 64'(hz.forward_mode_rs2), 64'(2'b11));
      step();

      // RAW stall on a pending multi-cycle destination, 10 stalled cycles.
      pulse_reset();
      issue(7);
      hz.rs2_DE = 7;
      for (int k = 1; k <= 10; k++) begin
         if (k == 10) begin
            hz.mc_done    = 1'b1;
            hz.mc_rd_done = 7;
         end
         step();
      end
      hz.mc_done = 1'b0;
      #1;
      check_eq("raw_release",  64'(hz.stall_DE),  64'(0));
      check_eq("stall_cnt_10", 64'(hz.stall_cnt), 64'(10));
      step();

      // Structural stall while the unit is occupied.
      issue(12);
      hz.mc_op_DE = 1'b1; hz.rs1_DE = 1; hz.rs2_DE = 2; hz.rd_DE = 4;
      repeat (4) step();
      hz.mc_done = 1'b1; hz.mc_rd_done = 12;
      step();
      hz.mc_done = 1'b0;
      #1 check_eq("struct_release", 64'(hz.stall_DE), 64'(0));
      step();

      // Same-cycle issue and completion on x3 keeps x3 pending.
      issue(3);
      hz.mc_issue_EX = 1'b1; hz.rd_EX = 3; hz.mc_done = 1'b1; hz.mc_rd_done = 3;
      step();
      set_idle();
      hz.rs1_DE = 3;
      #1 check_eq("same_cycle_busy", 64'(hz.stall_DE), 64'(1));
      step();
      set_idle();
      hz.mc_done = 1'b1; hz.mc_rd_done = 3;
      step();
      set_idle();
      step();

      // Misprediction overrides a load-use stall.
      hz.mem_read_en_EX = 1'b1; hz.rd_EX = 4; hz.rs1_DE = 4; hz.branch_control = 1'b1;
      #1;
      check_eq("lu_mis_flushDE", 64'(hz.flush_DE),          64'(1));
      check_eq("lu_mis_flushEX", 64'(hz.flush_EX),          64'(1));
      check_eq("lu_mis_bc",      64'(hz.branch_correction), 64'(1));
      check_eq("lu_mis_stallF",  64'(hz.stall_F),           64'(0));
      saved = mis_cnt_m;
      step();
      hz.branch_control = 1'b0; hz.program_counter_controller_EX = 2'd2;
      #1;
      check_eq("mis_cnt_inc",  64'(hz.mispredict_cnt),    64'(saved + 1));
      check_eq("lu_jump_fex",  64'(hz.flush_EX),          64'(1));
      check_eq("lu_jump_bc",   64'(hz.branch_correction), 64'(0));
      check_eq("lu_jump_stall",64'(hz.stall_DE),          64'(0));
      step();

      // Watchdog: no completion for MAX_LAT cycles, then reset clears it.
      pulse_reset();
      issue(3);
      repeat (MAX_LAT) step();
      #1 check_eq("timeout_not_early", 64'(hz.mc_timeout), 64'(0));
      step();
      #1 check_eq("timeout_set", 64'(hz.mc_timeout), 64'(1));
      hz.mc_done = 1'b1; hz.mc_rd_done = 3;
      step();
      set_idle();
      step();
      #1 check_eq("timeout_sticky", 64'(hz.mc_timeout), 64'(1));
      issue(3);
      pulse_reset();
      hz.rs1_DE = 3;
      #1;
      check_eq("rst_timeout_clr", 64'(hz.mc_timeout), 64'(0));
      check_eq("rst_busy_clr",    64'(hz.stall_DE),   64'(0));
      check_eq("rst_cnt_clr",     64'(hz.stall_cnt),  64'(0));
      step();

      // Stall counter saturation.
      pulse_reset();
      issue(9);
      hz.rs1_DE = 9;
      repeat (300) step();
      #1 check_eq("stall_cnt_sat", 64'(hz.stall_cnt), 64'(CNT_MAX));
      step();
      pulse_reset();

      // Randomized traffic on a small register window to provoke collisions.
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 99) == 0);
         hz.rs1_DE = REG_W'($urandom_range(0, 7));
         hz.rs2_DE = REG_W'($urandom_range(0, 7));
         hz.rd_DE  = REG_W'($urandom_range(0, 7));
         hz.rs1_EX = REG_W'($urandom_range(0, 7));
         hz.rs2_EX = REG_W'($urandom_range(0, 7));
         hz.rd_EX  = REG_W'($urandom_range(0, 7));
         hz.rd_MEM = REG_W'($urandom_range(0, 7));
         hz.rd_WB  = REG_W'($urandom_range(0, 7));
         hz.rf_write_en_MEM = $urandom_range(0, 1);
         hz.rf_write_en_WB  = $urandom_range(0, 1);
         hz.mem_read_en_EX  = ($urandom_range(0, 3) == 0);
         hz.program_counter_controller_EX = 2'($urandom_range(0, 3));
         hz.branch_control  = $urandom_range(0, 1);
         hz.branch_decision = ($urandom_range(0, 7) == 0) ? !hz.branch_control : hz.branch_control;
         hz.mc_op_DE    = ($urandom_range(0, 3) == 0);
         hz.mc_issue_EX = ($urandom_range(0, 4) == 0);
         hz.mc_done     = ($urandom_range(0, 4) == 0);
         hz.mc_rd_done  = REG_W'($urandom_range(0, 7));
         step();
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
